// File: rtl/obi_sram_responder.sv
// OBI responder backed by a word-organised scratchpad: programmable grant wait
// states, bounded outstanding count and fixed-latency pipelined responses.
package obi_sram_responder_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_sram_responder
  import obi_sram_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] OOR_RDATA       = 32'hBADC_AB1E
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  input  logic      gnt_stall_i,
  output logic      busy_o,
  output logic      oor_o
);
  // Handshake: a transfer happens in any cycle with req=1 and gnt=1; the master
  // holds req/we/be/addr/wdata stable until then. rvalid follows exactly
  // RESP_LATENCY cycles later, in grant order, and cannot be back-pressured.

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [3:0]                     wait_cnt_q, wait_cnt_d;
  logic [OW-1:0]                  outstanding_q, outstanding_d;
  logic [RESP_LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
  logic [RESP_LATENCY-1:0][31:0]  pipe_data_q, pipe_data_d;
  logic [31:0]                    mem_q [NUM_WORDS];

  logic [29:0]   off_word;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   resp_data;

  // BASE_ADDR is word aligned, so the offset is formed on word addresses only.
  assign off_word = obi_req_i.addr[31:2] - BASE_ADDR[31:2];
  assign idx      = off_word[AW-1:0];
  assign in_range = (obi_req_i.addr >= BASE_ADDR) && (32'(off_word) < NUM_WORDS);

  assign gnt = obi_req_i.req & rst_ni & ~gnt_stall_i
             & (wait_cnt_q == 4'(GNT_WAIT))
             & (outstanding_q < OW'(MAX_OUTSTANDING));

  assign rvalid    = rst_ni & pipe_vld_q[RESP_LATENCY-1];
  assign resp_data = obi_req_i.we ? 32'h0 : (in_range ? mem_q[idx] : OOR_RDATA);

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    outstanding_d = outstanding_q;
    pipe_vld_d    = '0;
    pipe_data_d   = '0;

    if (!obi_req_i.req || gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'(GNT_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (gnt && !rvalid) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!gnt && rvalid) begin
      outstanding_d = outstanding_q - OW'(1);
    end

    // Idle slots carry zero data so rdata is 0 whenever rvalid is low.
    pipe_vld_d[0]  = gnt;
    pipe_data_d[0] = gnt ? resp_data : 32'h0;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
      pipe_data_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_data_q   <= pipe_data_d;
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (gnt && obi_req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_req_i.be[b]) begin
          mem_q[idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  assign obi_resp_o.gnt    = gnt;
  assign obi_resp_o.rvalid = rvalid;
  assign obi_resp_o.rdata  = rvalid ? pipe_data_q[RESP_LATENCY-1] : 32'h0;
  assign busy_o            = rst_ni & (outstanding_q != '0);
  assign oor_o             = gnt & ~in_range;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder: three differently parameterised instances driven
// by directed and random OBI traffic, checked every cycle against a transaction model.
module tb_obi_sram_responder;
  import obi_sram_responder_pkg::*;

  localparam int ND    = 3;
  localparam int LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic      rst_n   [ND];
  obi_req_t  req_s   [ND];
  obi_resp_t resp_s  [ND];
  logic      stall_s [ND];
  logic      busy_s  [ND];
  logic      oor_s   [ND];

  // d0: defaults; d1: offset base, 3 wait states, latency 4; d2: small, latency 4
  obi_sram_responder u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .obi_req_i(req_s[0]), .obi_resp_o(resp_s[0]),
    .gnt_stall_i(stall_s[0]), .busy_o(busy_s[0]), .oor_o(oor_s[0]));

  obi_sram_responder #(.BASE_ADDR(32'h1000), .GNT_WAIT(3), .RESP_LATENCY(4),
                       .MAX_OUTSTANDING(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .obi_req_i(req_s[1]), .obi_resp_o(resp_s[1]),
    .gnt_stall_i(stall_s[1]), .busy_o(busy_s[1]), .oor_o(oor_s[1]));

  obi_sram_responder #(.NUM_WORDS(64), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .obi_req_i(req_s[2]), .obi_resp_o(resp_s[2]),
    .gnt_stall_i(stall_s[2]), .busy_o(busy_s[2]), .oor_o(oor_s[2]));

  function automatic int gw_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction
  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction
  function automatic int nw_of(input int d);
    return (d == 2) ? 64 : 256;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h1000 : 32'h0;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q [ND][$];     // {data_known, rdata} per granted transfer
  int          due_q [ND][$];     // cycle in which its rvalid is expected
  int          held  [ND];        // cycles req has waited since last grant/drop
  logic [31:0] mem_m   [ND][256];
  bit          known_m [ND][256];
  logic [31:0] last_rdata [ND];
  int          rv_cnt  [ND];
  int          oor_cnt [ND];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int d);
    bit          exp_gnt, exp_rv, inr;
    longint      off;
    int          w;
    logic [32:0] ent;
    string       p;
    p = $sformatf("d%0d_", d);
    if (resp_s[d].rvalid) begin
      rv_cnt[d]++;
      last_rdata[d] = resp_s[d].rdata;
    end
    if (oor_s[d]) oor_cnt[d]++;

    if (!rst_n[d]) begin
      chk({p, "rst_gnt"},    32'(resp_s[d].gnt),    0);
      chk({p, "rst_rvalid"}, 32'(resp_s[d].rvalid), 0);
      chk({p, "rst_rdata"},  resp_s[d].rdata,       0);
      chk({p, "rst_busy"},   32'(busy_s[d]),        0);
      chk({p, "rst_oor"},    32'(oor_s[d]),         0);
      exp_q[d].delete();
      due_q[d].delete();
      held[d] = 0;
      return;
    end

    off = longint'(req_s[d].addr) - longint'(base_of(d));
    inr = (off >= 0) && (off < 4 * nw_of(d));
    exp_gnt = req_s[d].req && (held[d] >= gw_of(d)) && !stall_s[d]
              && (exp_q[d].size() < 2);
    exp_rv  = (due_q[d].size() > 0) && (due_q[d][0] == cyc);

    chk({p, "gnt"},    32'(resp_s[d].gnt),    32'(exp_gnt));
    chk({p, "rvalid"}, 32'(resp_s[d].rvalid), 32'(exp_rv));
    chk({p, "busy"},   32'(busy_s[d]),        32'(exp_q[d].size() != 0));
    chk({p, "oor"},    32'(oor_s[d]),         32'(exp_gnt && !inr));

    if (exp_rv) begin
      ent = exp_q[d].pop_front();
      void'(due_q[d].pop_front());
      if (ent[32]) chk({p, "rdata"}, resp_s[d].rdata, ent[31:0]);
    end else begin
      chk({p, "rdata_idle"}, resp_s[d].rdata, 0);
    end

    if (exp_gnt) begin
      w = inr ? int'(off / 4) : 0;
      if (req_s[d].we) begin
        exp_q[d].push_back({1'b1, 32'h0});
        if (inr) begin
          for (int b = 0; b < 4; b++)
            if (req_s[d].be[b]) mem_m[d][w][8*b +: 8] = req_s[d].wdata[8*b +: 8];
          if (req_s[d].be == 4'hF) known_m[d][w] = 1'b1;
        end
      end else if (!inr) begin
        exp_q[d].push_back({1'b1, 32'hBADC_AB1E});
      end else begin
        exp_q[d].push_back({known_m[d][w], mem_m[d][w]});
      end
      due_q[d].push_back(cyc + lat_of(d));
      held[d] = 0;
    end else begin
      held[d] = req_s[d].req ? held[d] + 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) model_step(d);
  end

  // ---------------- driver tasks ----------------
  // Entered and left just after a rising edge; req stays high on return so
  // consecutive calls produce back-to-back requests.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input bit rand_stall, output int lat);
    req_s[d] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
    if (rand_stall) stall_s[d] = ($urandom_range(0, 2) == 0);
    lat = 0;
    forever begin
      @(negedge clk);
      if (resp_s[d].gnt) break;
      if (lat == LIMIT) begin
        chk($sformatf("d%0d_gnt_timeout", d), 32'(resp_s[d].gnt), 1);
        req_s[d].req = 1'b0;
        break;
      end
      lat++;
      @(posedge clk); #1;
      if (rand_stall) stall_s[d] = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    if (rand_stall) stall_s[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    req_s[d].req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int k;
    logic [31:0] addr;
    for (int d = 0; d < ND; d++) begin
      rst_n[d]      = 1'b0;
      req_s[d]      = '0;
      stall_s[d]    = 1'b0;
      held[d]       = 0;
      last_rdata[d] = 32'h0;
      rv_cnt[d]     = 0;
      oor_cnt[d]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;

    // Basic write then read with zero wait states
    do_txn(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, lat);
    chk("t1_wr_lat", lat, 0);
    do_txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, lat);
    chk("t1_rd_lat", lat, 0);
    idle(0, 3);
    chk("t1_rd_data", last_rdata[0], 32'hDEAD_BEEF);
    chk("t1_idle_busy", 32'(busy_s[0]), 0);

    // Byte enables, including an all-zero mask
    do_txn(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, lat);
    do_txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, lat);
    do_txn(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, lat);
    idle(0, 3);
    chk("t2_be_merge", last_rdata[0], 32'h11BB_33DD);
    do_txn(0, 1'b1, 32'h22, 4'h0, 32'hFFFF_FFFF, 1'b0, lat);
    do_txn(0, 1'b0, 32'h21, 4'hF, 32'h0, 1'b0, lat);
    idle(0, 3);
    chk("t2_be_zero", last_rdata[0], 32'h11BB_33DD);

    // Grant back-pressure for five cycles
    k = rv_cnt[0];
    stall_s[0] = 1'b1;
    fork
      do_txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, lat);
      begin
        repeat (5) @(posedge clk);
        #1;
        stall_s[0] = 1'b0;
      end
    join
    idle(0, 3);
    chk("t5_stall_lat", lat, 5);
    chk("t5_one_rvalid", rv_cnt[0] - k, 1);

    // Wait states with back-to-back reads held on req
    for (int i = 0; i < 6; i++) do_txn(1, 1'b1, 32'h1000 + 4 * i, 4'hF, 32'hA000_0000 + i, 1'b0, lat);
    idle(1, 6);
    for (int i = 0; i < 6; i++) begin
      do_txn(1, 1'b0, 32'h1000 + 4 * i, 4'hF, 32'h0, 1'b0, lat);
      chk($sformatf("t3_lat%0d", i), lat, 3);
    end
    idle(1, 6);
    chk("t3_last_data", last_rdata[1], 32'hA000_0005);

    // Out-of-range accesses around an offset base
    do_txn(1, 1'b1, 32'h13FC, 4'hF, 32'hCAFE_F00D, 1'b0, lat);
    k = oor_cnt[1];
    do_txn(1, 1'b1, 32'h0FFC, 4'hF, 32'h1234_5678, 1'b0, lat);
    do_txn(1, 1'b0, 32'h13FC, 4'hF, 32'h0, 1'b0, lat);
    idle(1, 6);
    chk("t4_top_word_kept", last_rdata[1], 32'hCAFE_F00D);
    do_txn(1, 1'b0, 32'h1400, 4'hF, 32'h0, 1'b0, lat);
    idle(1, 6);
    chk("t4_oor_rdata", last_rdata[1], 32'hBADC_AB1E);
    chk("t4_oor_pulses", oor_cnt[1] - k, 2);

    // Outstanding limit: third read waits for a slot freed after an rvalid cycle
    for (int i = 0; i < 4; i++) do_txn(2, 1'b1, 4 * i, 4'hF, 32'hC0DE_0000 + i, 1'b0, lat);
    do_txn(2, 1'b1, 32'h20, 4'hF, 32'h5A5A_1234, 1'b0, lat);
    idle(2, 6);
    do_txn(2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, lat);
    chk("t3b_lat0", lat, 0);
    do_txn(2, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, lat);
    chk("t3b_lat1", lat, 0);
    do_txn(2, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, lat);
    chk("t3b_full_lat", lat, 3);
    idle(2, 6);

    // Reset with two responses pending
    do_txn(2, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, lat);
    do_txn(2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, lat);
    k = rv_cnt[2];
    rst_n[2] = 1'b0;
    req_s[2].req = 1'b0;
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    idle(2, 8);
    chk("t6_no_rvalid", rv_cnt[2] - k, 0);
    chk("t6_busy", 32'(busy_s[2]), 0);
    do_txn(2, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, lat);
    idle(2, 6);
    chk("t6_mem_kept", last_rdata[2], 32'h5A5A_1234);

    // Request held across reset release restarts the wait count
    req_s[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h1004, wdata: 32'h0};
    rst_n[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    do_txn(1, 1'b0, 32'h1004, 4'hF, 32'h0, 1'b0, lat);
    chk("t6_held_req_lat", lat, 3);
    idle(1, 6);

    // Randomized traffic with random stalls, checked by the model every cycle
    for (int d = 0; d < ND; d++) begin
      for (int w = 0; w < 16; w++) do_txn(d, 1'b1, base_of(d) + 4 * w, 4'hF, $urandom, 1'b0, lat);
      for (int n = 0; n < 120; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (base_of(d) != 0 && $urandom_range(0, 1) == 1)
            addr = base_of(d) - 4 * $urandom_range(1, 16);
          else
            addr = base_of(d) + 4 * nw_of(d) + 4 * $urandom_range(0, 63);
        end else begin
          addr = base_of(d) + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        end
        do_txn(d, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom, 1'b1, lat);
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 8);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
